bcd_to_bin_seq: RTL and testbench

//  Sequential multi-digit BCD-to-binary converter (reverse double-dabble), one bit per clock.
//  It is the decode side of our BCD arithmetic path: packed BCD results from the BCD adder

---
 rtl/bcd_to_bin_seq_pkg.sv | 20 ++
 rtl/bcd_to_bin_seq_if.sv | 28 ++
 rtl/bcd_to_bin_seq_digit_adjust.sv | 18 +
 rtl/bcd_to_bin_seq.sv | 151 +++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_to_bin_seq_pkg.sv
// bcd_pkg: state encoding, digit constants and a digit-legality helper shared by the
// sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX    = 4'd9;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd8;
  localparam logic [DIGIT_W-1:0] ADJ_SUB    = 4'd3;

  function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: input and output valid/ready channels of the BCD-to-binary converter.
// The converter uses the slave modport; its producer/consumer side uses master.
interface bcd_to_bin_seq_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) ();

  logic                        in_valid;
  logic                        in_ready;
  logic [DIGITS*DIGIT_W-1:0]   bcd_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [BIN_W-1:0]            bin_out;
  logic                        err;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err
  );

endinterface

// File: rtl/bcd_to_bin_seq_digit_adjust.sv
// bcd_digit_adjust: one reverse double-dabble correction step for a single BCD digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  // A digit that picked up a weight-8 bit from the shift really held 5 in decimal terms.
  always_comb begin
    if (i_digit >= ADJ_THRESH) begin
      o_digit = i_digit - ADJ_SUB;
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: reverse double-dabble BCD-to-binary converter, one result bit per clock.
// Define BCD_CHECK_EN to build the non-BCD digit check that drives err.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_to_bin_seq_if.slave bus
);

  localparam int BCD_W = DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic [BCD_W-1:0]   w_bcd_shift;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [BIN_W-1:0]   r_bin;
  logic [BIN_W-1:0]   w_bin_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [BIN_W-1:0]   r_bin_out;
  logic               r_err;
  logic               w_accept;
  logic               w_release;
  logic               w_done_nxt;
  logic               w_err_q_nxt;

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_release   = r_out_valid && bus.out_ready;
  assign w_bcd_shift = {1'b0, r_bcd[BCD_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (w_bcd_shift[g*DIGIT_W +: DIGIT_W]),
      .o_digit (w_bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Next-state and working-register update: the BCD field drains into bin LSB-first.
  always_comb begin
    w_state_nxt = r_state;
    w_bcd_nxt   = r_bcd;
    w_bin_nxt   = r_bin;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_bcd_nxt   = bus.bcd_in;
          w_bin_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        w_bcd_nxt = w_bcd_adj;
        w_bin_nxt = {r_bcd[0], r_bin[BIN_W-1:1]};
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      DONE: begin
        if (w_release) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef BCD_CHECK_EN
  logic r_err_q;
  logic w_bad;

  // Any digit above 9 in the accepted word marks the whole conversion as bad.
  always_comb begin
    w_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      w_bad = w_bad | digit_bad(bus.bcd_in[d*DIGIT_W +: DIGIT_W]);
    end
  end

  assign w_err_q_nxt = w_accept ? w_bad : r_err_q;

  // Sticky error flag, captured at accept and held through the conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_q <= 1'b0;
    end else begin
      r_err_q <= w_err_q_nxt;
    end
  end
`else
  assign w_err_q_nxt = 1'b0;
`endif

  assign w_done_nxt = (w_state_nxt == DONE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcd   <= w_bcd_nxt;
      r_bin   <= w_bin_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs are registered from the next state so they line up exactly with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_bin_out   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= w_done_nxt;
      r_bin_out   <= (w_done_nxt && !w_err_q_nxt) ? w_bin_nxt : '0;
      r_err       <= w_done_nxt && w_err_q_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.bin_out   = r_bin_out;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: scoreboard bench for the sequential BCD-to-binary converter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int LAT    = BIN_W + 1;
  localparam int PERIOD = BIN_W + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [BIN_W:0] exp_q [$];

  always #5 clk = ~clk;

  bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic int bcd_value(input logic [BCD_W-1:0] b);
    int v = 0;
    for (int d = DIGITS - 1; d >= 0; d--) v = v * 10 + int'(b[d*4 +: 4]);
    return v;
  endfunction

  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    logic [BCD_W-1:0] b = '0;
    int t = v;
    for (int d = 0; d < DIGITS; d++) begin
      b[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  // Expected {err, bin_out} for a word.
  function automatic logic [BIN_W:0] expect_of(input logic [BCD_W-1:0] b);
`ifdef BCD_CHECK_EN
    logic bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) if (b[d*4 +: 4] > 4'd9) bad = 1'b1;
    if (bad) return {1'b1, {BIN_W{1'b0}}};
`endif
    return {1'b0, BIN_W'(bcd_value(b))};
  endfunction

  task automatic send_word(input logic [BCD_W-1:0] w);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 4 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_word_ready got %b want 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.bcd_in   = w;
    exp_q.push_back(expect_of(w));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.bin_out !== '0) begin errors++; $display("FAIL reset_bin_out got %0d want 0", bus.bin_out); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int lat;
    logic [BIN_W:0] e;
    bus.out_ready = 1'b1;
    send_word(12'h999);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 4 * LAT) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != LAT) begin errors++; $display("FAIL single_latency got %0d want %0d", lat, LAT); end
    e = exp_q.pop_front();
    checks++; if ({bus.err, bus.bin_out} !== e) begin errors++; $display("FAIL single_value got err=%b bin=%0d want err=%b bin=%0d", bus.err, bus.bin_out, e[BIN_W], e[BIN_W-1:0]); end
    checks++; if (dut.r_bcd !== '0) begin errors++; $display("FAIL single_residual got %h want 0", dut.r_bcd); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.bin_out !== '0) begin
      errors++; $display("FAIL single_return got ov=%b ir=%b bin=%0d want ov=0 ir=1 bin=0", bus.out_valid, bus.in_ready, bus.bin_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [BCD_W-1:0] words [3] = '{12'h000, 12'h512, 12'h087};
    int sent = 0, got = 0, last_acc = -1, cyc = 0;
    logic [BIN_W:0] e;
    bus.out_ready = 1'b1;
    while (got < 3 && cyc < 8 * PERIOD) begin
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious got bin=%0d want no output", bus.bin_out);
        end else begin
          e = exp_q.pop_front();
          if ({bus.err, bus.bin_out} !== e) begin errors++; $display("FAIL b2b_value got %0d want %0d", bus.bin_out, e[BIN_W-1:0]); end
        end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_overlap got in_ready=%b want 0", bus.in_ready); end
        got++;
      end
      if (sent < 3) begin
        bus.in_valid = 1'b1;
        bus.bcd_in   = words[sent];
        if (bus.in_ready === 1'b1) begin
          exp_q.push_back(expect_of(words[sent]));
          if (last_acc >= 0) begin
            checks++; if (cyc - last_acc != PERIOD) begin errors++; $display("FAIL b2b_period got %0d want %0d", cyc - last_acc, PERIOD); end
          end
          last_acc = cyc;
          sent++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (got != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [BIN_W:0] e;
    bus.out_ready = 1'b0;
    send_word(12'h256);
    bus.in_valid = 1'b1;
    bus.bcd_in   = 12'h777;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 4 * LAT) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != LAT) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, LAT); end
    e = exp_q.pop_front();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.err, bus.bin_out} !== e || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_stall_%0d got ov=%b bin=%0d ir=%b want ov=1 bin=%0d ir=0", i, bus.out_valid, bus.bin_out, bus.in_ready, e[BIN_W-1:0]);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.bin_out !== '0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got ov=%b bin=%0d ir=%b want ov=0 bin=0 ir=1", bus.out_valid, bus.bin_out, bus.in_ready);
    end
    repeat (2 * PERIOD) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_ignored_word got out_valid=%b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [BIN_W:0] e;
    bus.out_ready = 1'b1;
    send_word(12'h347);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.bin_out !== '0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got ir=%b ov=%b bin=%0d err=%b want 1 0 0 0", bus.in_ready, bus.out_valid, bus.bin_out, bus.err);
    end
    checks++; if (dut.r_bcd !== '0 || dut.r_cnt !== '0) begin errors++; $display("FAIL midrst_state got bcd=%h cnt=%0d want 0 0", dut.r_bcd, dut.r_cnt); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(12'h021);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 4 * LAT) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != LAT) begin errors++; $display("FAIL midrst_latency got %0d want %0d", lat, LAT); end
    e = exp_q.pop_front();
    checks++; if ({bus.err, bus.bin_out} !== e) begin errors++; $display("FAIL midrst_value got %0d want %0d", bus.bin_out, e[BIN_W-1:0]); end
    @(negedge clk);
  endtask

`ifdef BCD_CHECK_EN
  task automatic test_bcd_check();
    logic [BCD_W-1:0] words [2] = '{12'h9A5, 12'h905};
    int lat;
    logic [BIN_W:0] e;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send_word(words[k]);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 4 * LAT) begin
        @(negedge clk);
        lat++;
      end
      checks++; if (lat != LAT) begin errors++; $display("FAIL check_latency_%0d got %0d want %0d", k, lat, LAT); end
      e = exp_q.pop_front();
      checks++; if ({bus.err, bus.bin_out} !== e) begin
        errors++; $display("FAIL check_value_%0d got err=%b bin=%0d want err=%b bin=%0d", k, bus.err, bus.bin_out, e[BIN_W], e[BIN_W-1:0]);
      end
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_exhaustive();
    int nxt = 0, got = 0, cyc = 0;
    logic [BIN_W:0] e;
    while (got < 1000 && cyc < 40000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL exh_spurious got bin=%0d want no output", bus.bin_out);
        end else begin
          e = exp_q.pop_front();
          if ({bus.err, bus.bin_out} !== e) begin errors++; $display("FAIL exh_value got err=%b bin=%0d want err=%b bin=%0d", bus.err, bus.bin_out, e[BIN_W], e[BIN_W-1:0]); end
        end
        checks++; if (dut.r_bcd !== '0) begin errors++; $display("FAIL exh_residual got %h want 0", dut.r_bcd); end
        got++;
      end
      if (nxt < 1000) begin
        bus.in_valid = 1'b1;
        bus.bcd_in   = to_bcd(nxt);
        if (bus.in_ready === 1'b1) begin
          exp_q.push_back(expect_of(to_bcd(nxt)));
          nxt++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got != 1000) begin errors++; $display("FAIL exh_count got %0d want 1000", got); end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef BCD_CHECK_EN
    test_bcd_check();
`endif
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
